// File: rtl/histogram_reduce.sv
// Histogram reduce stage: adds each bin of the map-stage histogram into the
// result memory and sums all bins into a total. Each bin takes one RD cycle and one WR cycle.
module histogram_reduce #(
    parameter int BINS   = 256,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [7:0]        hist_address0,
    output logic              hist_ce0,
    input  logic [DATA_W-1:0] hist_q0,
    output logic [7:0]        out_address1,
    output logic              out_ce1,
    input  logic [DATA_W-1:0] out_q1,
    output logic [7:0]        out_address0,
    output logic              out_ce0,
    output logic              out_we0,
    output logic [DATA_W-1:0] out_d0,
    output logic [DATA_W-1:0] total,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BINS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_idx;
    logic              r_done;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_total;

    logic              w_last;
    logic              w_accept;
    logic              w_finish;
    logic [DATA_W-1:0] w_acc_next;

    // Block-level handshake: ap_start is taken in IDLE only while no completion
    // is pending. ap_done/ap_ready pulse together in the final WR cycle. After that
    // ap_done follows r_done until the consumer raises ap_continue.
    assign w_last     = (r_idx == LAST_IDX);
    assign w_accept   = (r_state == S_IDLE) && ap_start && !r_done;
    assign w_finish   = (r_state == S_WR) && w_last;
    assign w_acc_next = r_acc + hist_q0;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_RD;
            S_RD:    w_next_state = S_WR;
            S_WR:    w_next_state = w_last ? S_IDLE : S_RD;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_idx <= 8'd0;
        end else if (w_accept) begin
            r_idx <= 8'd0;
        end else if ((r_state == S_WR) && !w_last) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_state == S_WR) begin
            r_acc <= w_acc_next;
        end
    end

    // total moves only when an invocation completes, so it keeps the previous
    // result while the next invocation is running.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_total <= '0;
        end else if (w_finish) begin
            r_total <= w_acc_next;
        end
    end

    // If continue and completion arrive in the same cycle, continue takes priority.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_done <= 1'b0;
        end else if (ap_continue) begin
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_done <= 1'b1;
        end
    end

    always_comb begin
        hist_ce0      = 1'b0;
        hist_address0 = 8'd0;
        out_ce1       = 1'b0;
        out_address1  = 8'd0;
        out_ce0       = 1'b0;
        out_we0       = 1'b0;
        out_address0  = 8'd0;
        out_d0        = '0;
        case (r_state)
            S_RD: begin
                hist_ce0      = 1'b1;
                hist_address0 = r_idx;
                out_ce1       = 1'b1;
                out_address1  = r_idx;
            end
            S_WR: begin
                out_ce0      = 1'b1;
                out_we0      = 1'b1;
                out_address0 = r_idx;
                out_d0       = hist_q0 + out_q1;
            end
            default: ;
        endcase
    end

    assign ap_done   = w_finish || r_done;
    assign ap_ready  = w_finish;
    assign ap_idle   = (r_state == S_IDLE) && !ap_start;
    assign total     = r_total;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_histogram_reduce.sv
// Randomized self-checking bench for histogram_reduce: memory responders, a
// bin-level reference model and a queue scoreboard of expected result words.
module tb_histogram_reduce;

    localparam int BINS   = 256;
    localparam int DATA_W = 32;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_continue;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [7:0]        hist_address0;
    logic              hist_ce0;
    logic [DATA_W-1:0] hist_q0;
    logic [7:0]        out_address1;
    logic              out_ce1;
    logic [DATA_W-1:0] out_q1;
    logic [7:0]        out_address0;
    logic              out_ce0;
    logic              out_we0;
    logic [DATA_W-1:0] out_d0;
    logic [DATA_W-1:0] total;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] hist_mem [BINS];
    logic [DATA_W-1:0] out_mem  [BINS];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_total;
    logic [DATA_W-1:0] last_total;
    logic [7:0]        prev_haddr;

    int n_checks;
    int n_pass;

    histogram_reduce #(.BINS(BINS), .DATA_W(DATA_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_continue(ap_continue), .ap_done(ap_done), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .hist_address0(hist_address0), .hist_ce0(hist_ce0),
        .hist_q0(hist_q0), .out_address1(out_address1), .out_ce1(out_ce1),
        .out_q1(out_q1), .out_address0(out_address0), .out_ce0(out_ce0),
        .out_we0(out_we0), .out_d0(out_d0), .total(total), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory responders ----------------
    always @(posedge ap_clk) begin
        if (hist_ce0) hist_q0 <= hist_mem[hist_address0];
        if (out_ce1) out_q1 <= out_mem[out_address1];
        if (out_ce0 && out_we0) out_mem[out_address0] = out_d0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    // Per-cycle protocol monitor.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_we0) check("wr_addr_follows_rd", {24'd0, out_address0}, {24'd0, prev_haddr});
            if (hist_ce0 || out_we0) check("rd_wr_exclusive", {31'd0, hist_ce0 & out_we0}, 32'd0);
            check("ce1_with_ce0", {31'd0, out_ce1}, {31'd0, hist_ce0});
            check("ce0_with_we0", {31'd0, out_ce0}, {31'd0, out_we0});
        end
        prev_haddr = hist_address0;
    end

    // ---------------- reference model / scoreboard ----------------
    // Bins below nbins receive out+hist; the rest stay as they are.
    task automatic build_expect(input int nbins);
        exp_q.delete();
        exp_total = '0;
        for (int k = 0; k < BINS; k++) begin
            if (k < nbins) begin
                exp_q.push_back(out_mem[k] + hist_mem[k]);
                exp_total = exp_total + hist_mem[k];
            end else begin
                exp_q.push_back(out_mem[k]);
            end
        end
    endtask

    task automatic check_mem(input string tag);
        check({tag, "_qsize"}, exp_q.size(), BINS);
        for (int k = 0; k < BINS; k++) begin
            if (exp_q.size() != 0) check(tag, out_mem[k], exp_q.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    // Called on the first negedge after the accepting edge.
    task automatic wait_finish(input bit chk_lat);
        int n;
        n = 1;
        while (!ap_done && n < 3 * BINS) begin
            @(negedge ap_clk);
            n++;
        end
        if (chk_lat) check("latency", n, 2 * BINS);
        check("ready_pulse", {31'd0, ap_ready}, 32'd1);
        check("total_hold", total, last_total);
        @(negedge ap_clk);
        check("ready_low", {31'd0, ap_ready}, 32'd0);
        check("done_held", {31'd0, ap_done}, 32'd1);
        check("total", total, exp_total);
        last_total = exp_total;
    endtask

    task automatic run(input bit chk_lat);
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_finish(chk_lat);
    endtask

    task automatic ack();
        ap_continue = 1'b1;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        check("done_clr", {31'd0, ap_done}, 32'd0);
        check("idle_after_ack", {31'd0, ap_idle}, 32'd1);
    endtask

    task automatic fill_random();
        for (int k = 0; k < BINS; k++) begin
            hist_mem[k] = (($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 : 32'd0) | $urandom;
            out_mem[k]  = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        n_checks    = 0;
        n_pass      = 0;
        last_total  = '0;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        ap_rst_n    = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            hist_mem[k] = k;
            out_mem[k]  = '0;
        end
        repeat (3) @(negedge ap_clk);
        check("rst_done", {31'd0, ap_done}, 32'd0);
        check("rst_ready", {31'd0, ap_ready}, 32'd0);
        check("rst_idle", {31'd0, ap_idle}, 32'd1);
        check("rst_hist_ce0", {31'd0, hist_ce0}, 32'd0);
        check("rst_out_we0", {31'd0, out_we0}, 32'd0);
        check("rst_total", total, 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Ramp histogram into a zeroed result memory.
        build_expect(BINS);
        check("ramp_total_model", exp_total, 32'd32640);
        run(1'b1);
        check_mem("ramp_out");
        ack();

        // Two back-to-back invocations of all-ones.
        for (int k = 0; k < BINS; k++) begin
            hist_mem[k] = 32'd1;
            out_mem[k]  = '0;
        end
        for (int r = 0; r < 2; r++) begin
            build_expect(BINS);
            run(1'b1);
            check("ones_total", total, 32'd256);
            check_mem("ones_out");
            ack();
        end
        check("ones_out0_is_2", out_mem[0], 32'd2);

        // Wrap in one bin; every other bin adds zero.
        for (int k = 0; k < BINS; k++) begin
            hist_mem[k] = '0;
            out_mem[k]  = $urandom;
        end
        hist_mem[5] = 32'd2;
        out_mem[5]  = 32'hFFFF_FFFF;
        build_expect(BINS);
        run(1'b1);
        check_mem("wrap_out");
        check("wrap_bin5", out_mem[5], 32'd1);
        ack();

        // Completion pending with start held high: nothing may be accepted.
        fill_random();
        build_expect(BINS);
        run(1'b1);
        check_mem("rand_a_out");
        fill_random();
        build_expect(BINS);
        ap_start = 1'b1;
        repeat (8) begin
            @(negedge ap_clk);
            check("held_done", {31'd0, ap_done}, 32'd1);
            check("held_no_rd", {31'd0, hist_ce0}, 32'd0);
        end
        ap_continue = 1'b1;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        check("cont_done_clr", {31'd0, ap_done}, 32'd0);
        check("cont_no_rd_yet", {31'd0, hist_ce0}, 32'd0);
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("cont_accept_rd", {31'd0, hist_ce0}, 32'd1);
        check("cont_accept_addr", {24'd0, hist_address0}, 32'd0);
        wait_finish(1'b1);
        check_mem("rand_b_out");
        ack();

        // Random runs with random gaps before the acknowledge.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            build_expect(BINS);
            run(1'b1);
            check_mem("rand_out");
            repeat ($urandom_range(0, 3)) @(negedge ap_clk);
            check("rand_done_wait", {31'd0, ap_done}, 32'd1);
            ack();
        end

        // Reset during bin 100.
        fill_random();
        build_expect(100);
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        guard = 0;
        while (!(hist_ce0 && hist_address0 == 8'd100) && guard < 3 * BINS) begin
            @(negedge ap_clk);
            guard++;
        end
        check("abort_reached_bin100", {24'd0, hist_address0}, 32'd100);
        ap_rst_n = 1'b0;
        #1;
        check("abort_hist_ce0", {31'd0, hist_ce0}, 32'd0);
        check("abort_out_ce1", {31'd0, out_ce1}, 32'd0);
        check("abort_out_we0", {31'd0, out_we0}, 32'd0);
        check("abort_done", {31'd0, ap_done}, 32'd0);
        check("abort_total", total, 32'd0);
        check("abort_idle", {31'd0, ap_idle}, 32'd1);
        repeat (3) @(negedge ap_clk);
        check_mem("abort_out");

        // First edge after reset release with start high must be accepted.
        last_total = '0;
        build_expect(BINS);
        ap_rst_n = 1'b1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("post_rst_rd", {31'd0, hist_ce0}, 32'd1);
        check("post_rst_addr", {24'd0, hist_address0}, 32'd0);
        wait_finish(1'b1);
        check_mem("post_rst_out");
        ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/histogram_reduce.md
HISTOGRAM_REDUCE -- requirements
Module: histogram_reduce

Interface
REQ-001 SHALL have parameter BINS, default 256, meaning number of histogram bins read per invocation (power of two, 2..256).
REQ-002 SHALL have parameter DATA_W, default 32, meaning bin count width.
REQ-003 SHALL have port ap_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ap_start  input  1  invocation request.
REQ-006 SHALL have port ap_continue  input  1  consumer acknowledge of completion.
REQ-007 SHALL have port ap_done  output  1  invocation complete (held until continue).
REQ-008 SHALL have port ap_idle  output  1  in IDLE with ap_start low.
REQ-009 SHALL have port ap_ready  output  1  ready for next ap_start (one cycle pulse).
REQ-010 SHALL have ports hist_address0  output  8, hist_ce0  output  1, hist_q0  input  DATA_W  read port of the ping-pong histogram buffer written by the map stage; 1-cycle read latency.
REQ-011 SHALL have ports out_address1  output  8, out_ce1  output  1, out_q1  input  DATA_W  read port of the accumulated result memory; 1-cycle latency.
REQ-012 SHALL have ports out_address0  output  8, out_ce0  output  1, out_we0  output  1, out_d0  output  DATA_W  write port of the result memory.
REQ-013 SHALL have port total  output  DATA_W  sum of all hist bins read in the last completed invocation.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR.
REQ-015 IDLE -> RD SHALL occur when ap_start=1 and done_reg=0; bin index i cleared to 0 and total accumulator cleared to 0 on that edge.
REQ-016 In RD, SHALL assert hist_ce0=1, hist_address0=i, out_ce1=1, out_address1=i; all write strobes 0; next state WR.
REQ-017 In WR, SHALL assert out_ce0=1, out_we0=1, out_address0=i, out_d0=hist_q0+out_q1 truncated to DATA_W (wrap mod 2^DATA_W); accumulator += hist_q0 (wrapping).
REQ-018 WR with i<BINS-1 SHALL increment i and go to RD; WR with i==BINS-1 SHALL go to IDLE, load total with final accumulator value, set done_reg.
REQ-019 ap_done and ap_ready SHALL be asserted combinationally in the final WR cycle; afterwards ap_done SHALL equal done_reg.
REQ-020 done_reg SHALL clear on any cycle with ap_continue=1 (continue wins over setting in the same cycle); while done_reg=1, ap_start SHALL be ignored.
REQ-021 Latency from accepting edge to ap_done SHALL be exactly 2*BINS cycles (RD/WR per bin); no bubbles.
REQ-022 Outside RD/WR all ce/we strobes SHALL be 0; addresses are don't-care but SHALL be driven to 0.
REQ-023 total SHALL change only at completion; it holds across idle and a new invocation until that invocation completes.
REQ-024 ap_idle SHALL be 1 only in IDLE with ap_start=0.

Reset
REQ-025 While ap_rst_n=0: state IDLE, i=0, done_reg=0, accumulator=0, total=0, all strobes, ap_done, ap_ready 0, ap_idle=1 if ap_start=0.
REQ-026 Reset asserted mid-invocation SHALL abort immediately with no further memory writes; the partially updated result memory is not restored.
REQ-027 After ap_rst_n rises, first invocation SHALL be accepted on the first edge with ap_start=1.

Verification
REQ-028 BINS=256, hist[k]=k, out all 0, start pulse -> out[k]=k, total=32640, ap_done high exactly 512 cycles after accept.
REQ-029 Two invocations, hist[k]=1 each, continue between -> out[k]=2, total=256 after each run.
REQ-030 out[5]=0xFFFFFFFF, hist[5]=2 -> out[5]=1 (wrap), no other bin affected.
REQ-031 ap_continue held 0 after done, ap_start held 1 -> ap_done stays 1, no RD strobe; continue=1 -> next cycle accept, RD on i=0.
REQ-032 ap_rst_n low at bin 100 -> strobes 0 same cycle, out[0..99] updated, out[100..255] unchanged, total=0.
REQ-033 Check every cycle: out_we0 only in WR, hist_ce0 only in RD, out_address0 equals previous cycle's hist_address0.
